guard_reset_sequencer: RTL

Sequences recovery after an AXI guard timeout. It collects the reset requests from the write and read guards and isolates the guarded subordinate. It then drains or times out pending handshakes, drives the subordinate reset for a programmed duration, and waits a recovery interval. Finally it pulses the guards' `reset_clear_i` and returns to idle. It sits between the write/read guards, the AXI isolation logic and the subordinate's reset input.

---
 rtl/guard_reset_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/guard_reset_sequencer.sv
// Recovery sequencer for AXI guard timeouts: isolate, drain, reset the subordinate, recover, clear guards.
// Optional statistics (seq_count_o, drain_to_o) are built only when GUARD_SEQ_STATS_EN is defined.
module guard_reset_sequencer #(
  parameter int CntWidth  = 8,
  parameter bit AutoClear = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_reset_req_i,
  input  logic                rd_reset_req_i,
  input  logic                hs_pending_i,
  input  logic [CntWidth-1:0] drain_cycles_i,
  input  logic [CntWidth-1:0] rst_cycles_i,
  input  logic [CntWidth-1:0] recover_cycles_i,
  input  logic                sw_clear_i,
  input  logic                irq_clr_i,
  output logic                isolate_o,
  output logic                slv_rst_o,
  output logic                guard_clear_o,
  output logic                irq_o,
  output logic                busy_o,
  output logic [1:0]          cause_o,
  output logic [15:0]         seq_count_o,
  output logic                drain_to_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_RESET   = 3'd2,
    S_RECOVER = 3'd3,
    S_CLEAR   = 3'd4
  } state_t;

  state_t              state_q;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] lim_q;
  logic [CntWidth-1:0] cnt_inc;
  logic                holdoff_q;
  logic [1:0]          req;
  logic                cnt_done;
  logic                drain_exit;

  assign req        = {rd_reset_req_i, wr_reset_req_i};
  assign cnt_inc    = cnt_q + CntWidth'(1);
  // A phase lasts max(limit, 1) cycles; the counter holds once this is true.
  assign cnt_done   = (lim_q == '0) || (cnt_inc == lim_q);
  assign drain_exit = !hs_pending_i || cnt_done;
  assign state_o    = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      lim_q         <= '0;
      holdoff_q     <= 1'b0;
      isolate_o     <= 1'b0;
      slv_rst_o     <= 1'b0;
      guard_clear_o <= 1'b0;
      irq_o         <= 1'b0;
      busy_o        <= 1'b0;
      cause_o       <= 2'b00;
    end else begin
      guard_clear_o <= 1'b0;
      if (irq_clr_i) irq_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          holdoff_q <= 1'b0;
          if ((|req) && !holdoff_q) begin
            state_q   <= S_DRAIN;
            cause_o   <= req;
            irq_o     <= 1'b1;
            lim_q     <= drain_cycles_i;
            cnt_q     <= '0;
            isolate_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end
        S_DRAIN: begin
          cause_o <= cause_o | req;
          if (drain_exit) begin
            state_q   <= S_RESET;
            lim_q     <= rst_cycles_i;
            cnt_q     <= '0;
            slv_rst_o <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_RESET: begin
          cause_o <= cause_o | req;
          if (cnt_done) begin
            state_q   <= S_RECOVER;
            lim_q     <= recover_cycles_i;
            cnt_q     <= '0;
            slv_rst_o <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_RECOVER: begin
          cause_o <= cause_o | req;
          if (cnt_done) begin
            if (AutoClear || sw_clear_i) begin
              state_q       <= S_CLEAR;
              guard_clear_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_CLEAR: begin
          // Holdoff masks the guard request that is still high for one cycle after the clear.
          state_q   <= S_IDLE;
          holdoff_q <= 1'b1;
          isolate_o <= 1'b0;
          busy_o    <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          isolate_o <= 1'b0;
          slv_rst_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

`ifdef GUARD_SEQ_STATS_EN
  logic [15:0] seq_count_q;
  logic        drain_to_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_count_q <= 16'h0000;
      drain_to_q  <= 1'b0;
    end else begin
      if (state_q == S_CLEAR && seq_count_q != 16'hFFFF) seq_count_q <= seq_count_q + 16'h0001;
      if (state_q == S_DRAIN && drain_exit) drain_to_q <= hs_pending_i;
    end
  end

  assign seq_count_o = seq_count_q;
  assign drain_to_o  = drain_to_q;
`else
  assign seq_count_o = 16'h0000;
  assign drain_to_o  = 1'b0;
`endif

endmodule
